// File: rtl/video_timing_if.sv
// Raster timing bundle: enable/restart controls in, position, syncs and strobes out.
// The generator uses the master modport; pattern generators and framebuffer readers use slave.
interface video_timing_if #(
    parameter int unsigned CNT_W = 10
) ();
    logic             en;
    logic             resync;
    logic             pixel_tick;
    logic [CNT_W-1:0] hpos;
    logic [CNT_W-1:0] vpos;
    logic             hsync;
    logic             vsync;
    logic             display_on;
    logic             line_start;
    logic             frame_start;
    logic [15:0]      frame_cnt;

    modport master (
        input  en,
        input  resync,
        output pixel_tick,
        output hpos,
        output vpos,
        output hsync,
        output vsync,
        output display_on,
        output line_start,
        output frame_start,
        output frame_cnt
    );

    modport slave (
        output en,
        output resync,
        input  pixel_tick,
        input  hpos,
        input  vpos,
        input  hsync,
        input  vsync,
        input  display_on,
        input  line_start,
        input  frame_start,
        input  frame_cnt
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with prescaled pixel tick, registered position,
// syncs, display enable, line/frame strobes and a frame counter.
module video_timing_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_BOTTOM  = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_TOP     = 33,
    parameter int unsigned PRESCALE  = 4,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CNT_W     = 10
) (
    input logic            clk,
    input logic            reset_n,
    video_timing_if.master vt
);
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int unsigned PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_DISP     = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_DISP     = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_DISPLAY + V_BOTTOM);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    logic [PW-1:0]    presc_q;
    logic [CNT_W-1:0] hpos_q, vpos_q;
    logic             hsync_q, vsync_q, disp_q;
    logic             tick_q, line_q, frame_q;
    logic [15:0]      fcnt_q;

    logic             advance, h_wrap, v_wrap;
    logic [CNT_W-1:0] hpos_d, vpos_d;
    logic             hsync_d, vsync_d, disp_d;

    // Decode from the next position so syncs land on the same edge as hpos/vpos.
    always_comb begin
        advance = vt.en && (presc_q == PRESC_LAST);
        h_wrap  = (hpos_q == H_LAST);
        v_wrap  = (vpos_q == V_LAST);
        hpos_d  = hpos_q + CNT_W'(1);
        vpos_d  = vpos_q;
        if (h_wrap) begin
            hpos_d = '0;
            vpos_d = v_wrap ? '0 : vpos_q + CNT_W'(1);
        end
        hsync_d = ((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = ((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
        disp_d  = (hpos_d < H_DISP) && (vpos_d < V_DISP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            hpos_q  <= '0;
            vpos_q  <= '0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            disp_q  <= 1'b1;
            tick_q  <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            fcnt_q  <= '0;
        end else if (vt.resync) begin
            // Park at (0,0) without strobes; frame_cnt keeps its history.
            presc_q <= '0;
            hpos_q  <= '0;
            vpos_q  <= '0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            disp_q  <= 1'b1;
            tick_q  <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else if (vt.en) begin
            tick_q  <= advance;
            line_q  <= advance && h_wrap;
            frame_q <= advance && h_wrap && v_wrap;
            if (advance) begin
                presc_q <= '0;
                hpos_q  <= hpos_d;
                vpos_q  <= vpos_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
                disp_q  <= disp_d;
                if (h_wrap && v_wrap) begin
                    fcnt_q <= fcnt_q + 16'd1;
                end
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end else begin
            tick_q  <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end
    end

    assign vt.pixel_tick  = tick_q;
    assign vt.hpos        = hpos_q;
    assign vt.vpos        = vpos_q;
    assign vt.hsync       = hsync_q;
    assign vt.vsync       = vsync_q;
    assign vt.display_on  = disp_q;
    assign vt.line_start  = line_q;
    assign vt.frame_start = frame_q;
    assign vt.frame_cnt   = fcnt_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 15x8 raster (PRESCALE=2) plus a PRESCALE=1 instance.
module tb_video_timing_gen;
    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    video_timing_if #(.CNT_W(10)) vt ();
    video_timing_if #(.CNT_W(10)) vt1 ();

    video_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1),
        .PRESCALE(2), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(10)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .vt(vt)
    );

    video_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1),
        .PRESCALE(1), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(10)
    ) dut_p1 (
        .clk(clk),
        .reset_n(reset_n),
        .vt(vt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Packed view: {tick, hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt}
    function automatic logic [63:0] snap();
        return {22'd0, vt.pixel_tick, vt.hpos, vt.vpos, vt.hsync, vt.vsync, vt.display_on,
                vt.line_start, vt.frame_start, vt.frame_cnt};
    endfunction

    function automatic logic [63:0] expect_at(input bit tick, input int h, input int v,
                                              input int fc);
        logic hs, vs, disp, ls, fs;
        hs   = !(h >= 10 && h <= 12);
        vs   = !(v >= 5 && v <= 6);
        disp = (h < 8) && (v < 4);
        ls   = tick && (h == 0);
        fs   = ls && (v == 0);
        return {22'd0, tick, 10'(h), 10'(v), hs, vs, disp, ls, fs, 16'(fc)};
    endfunction

    initial begin
        int p;
        int hs_low, disp_cnt, vs_low, ls_cnt, fs_cnt;
        errors   = 0;
        checks   = 0;
        reset_n  = 1'b0;
        vt.en    = 1'b0;
        vt.resync = 1'b0;
        vt1.en   = 1'b1;
        vt1.resync = 1'b0;
        hs_low = 0; disp_cnt = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0;

        #12;
        check("reset_state", snap(), expect_at(1'b0, 0, 0, 0));

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        vt.en   = 1'b1;

        // Two full frames: tick on every 2nd clk, position index = k/2.
        for (int k = 1; k <= 480; k++) begin
            step(1);
            p = k / 2;
            check($sformatf("scan_k%0d", k), snap(),
                  expect_at((k % 2) == 0, p % 15, (p / 15) % 8, p / 120));
            if (k <= 240 && vt.pixel_tick) begin
                if (vt.vpos == 0 && !vt.hsync) hs_low++;
                if (vt.vpos == 0 && vt.display_on) disp_cnt++;
                if (!vt.vsync) vs_low++;
                if (vt.line_start) ls_cnt++;
                if (vt.frame_start) fs_cnt++;
            end
        end
        check("line0_hsync_ticks", 64'(hs_low), 64'd3);
        check("line0_display_ticks", 64'(disp_cnt), 64'd8);
        check("frame_vsync_ticks", 64'(vs_low), 64'd30);
        check("frame_line_starts", 64'(ls_cnt), 64'd8);
        check("frame_starts", 64'(fs_cnt), 64'd1);

        // Freeze mid-line at hpos=5.
        step(10);
        check("pre_freeze", snap(), expect_at(1'b1, 5, 0, 2));
        vt.en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            check($sformatf("frozen_%0d", i), snap(), expect_at(1'b0, 5, 0, 2));
        end
        vt.en = 1'b1;
        step(1);
        check("resume_1", snap(), expect_at(1'b0, 5, 0, 2));
        step(1);
        check("resume_2", snap(), expect_at(1'b1, 6, 0, 2));

        // Resync from (12,6).
        step(192);
        check("pre_resync", snap(), expect_at(1'b1, 12, 6, 2));
        vt.resync = 1'b1;
        step(1);
        check("resync_park", snap(), expect_at(1'b0, 0, 0, 2));
        step(4);
        check("resync_held", snap(), expect_at(1'b0, 0, 0, 2));
        vt.resync = 1'b0;
        step(1);
        check("post_resync_1", snap(), expect_at(1'b0, 0, 0, 2));
        step(1);
        check("post_resync_2", snap(), expect_at(1'b1, 1, 0, 2));

        // Asynchronous reset between edges.
        step(7);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset", snap(), expect_at(1'b0, 0, 0, 0));
        check("async_reset_p1", {vt1.pixel_tick, vt1.hpos, vt1.vpos}, 21'd0);
        #1;
        reset_n = 1'b1;

        // PRESCALE=1 instance ticks on every clk.
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check($sformatf("p1_k%0d", k), {vt1.pixel_tick, vt1.hpos, vt1.vpos},
                  {1'b1, 10'(k % 15), 10'(k / 15)});
        end
        check("p1_line_start", {63'd0, vt1.line_start}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
